// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and sizing helpers for mem_pmem.
// Under PMEM_PARITY_EN, rsp_t also carries a parity-error flag.
package pmem_pkg;
    localparam int MAX_DATA_W = 64;
    typedef enum logic {INIT, RUN} pmem_state_e;
    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
`ifdef PMEM_PARITY_EN
        logic                  perr;
`endif
    } rsp_t;
    function automatic int pmem_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction
    function automatic int pmem_cnt_w(input int rsp_depth);
        return $clog2(rsp_depth + 1);
    endfunction
endpackage

// File: rtl/pmem_rsp_fifo.sv
// pmem_rsp_fifo: in-order response queue of rsp_t; an occupancy register drives full/empty.
module pmem_rsp_fifo
    import pmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  rsp_t din,
    output rsp_t dout,
    output logic empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    rsp_t buf_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic full, do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = buf_q[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) buf_q[wr_ptr] <= din;
endmodule

// File: rtl/mem_pmem.sv
// mem_pmem: single-port RAM with request handshake, RD_LAT read pipeline, response queue and zero-init.
// Define PMEM_PARITY_EN for a stored even-parity bit per word plus rd_perr/perr_inj ports.
module mem_pmem
    import pmem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rd_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
`ifdef PMEM_PARITY_EN
    input  logic              perr_inj,
    output logic              rd_perr,
`endif
    output logic              init_done
);
    localparam int DEPTH = pmem_depth(ADDR_W);
    localparam int CNT_W = pmem_cnt_w(RSP_DEPTH);
    pmem_state_e state, state_nxt;
    logic [ADDR_W-1:0] init_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef PMEM_PARITY_EN
    logic par [DEPTH];
`endif
    rsp_t pipe [RD_LAT];
    logic [RD_LAT-1:0] pipe_v;
    rsp_t rd_word, head;
    logic accept, rd_acc, wr_acc, rsp_hs, rsp_empty, unused_head;
    assign ready       = (state == RUN) && (outstanding < CNT_W'(RSP_DEPTH));
    assign accept      = rst && enable && ready;
    assign rd_acc      = accept && rd_wr;
    assign wr_acc      = accept && !rd_wr;
    assign rd_valid    = !rsp_empty;
    assign rsp_hs      = rd_valid && rd_ready;
    assign init_done   = (state == RUN);
    assign rd_data     = rd_valid ? head.data[DATA_W-1:0] : '0;
    assign unused_head = ^head.data;
`ifdef PMEM_PARITY_EN
    assign rd_perr     = rd_valid && head.perr;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) init_ptr <= init_ptr + 1'b1;
        end
    end
    always_comb state_nxt = (state == INIT && &init_ptr) ? RUN : state;
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            mem[init_ptr] <= '0;
`ifdef PMEM_PARITY_EN
            par[init_ptr] <= 1'b0;
`endif
        end else if (wr_acc) begin
            mem[addr] <= wr_data;
`ifdef PMEM_PARITY_EN
            par[addr] <= ^wr_data ^ perr_inj;
`endif
        end
    end
    always_comb begin
        rd_word      = '0;
        rd_word.data = MAX_DATA_W'(mem[addr]);
`ifdef PMEM_PARITY_EN
        rd_word.perr = (^mem[addr]) ^ par[addr];
`endif
    end
    // Valid bits are flushed on reset; payload stages need no reset.
    always_ff @(posedge clk) begin
        pipe[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (!rst) pipe_v <= '0;
        else begin
            pipe_v[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end
    always_ff @(posedge clk)
        outstanding <= !rst ? '0 : outstanding + CNT_W'(rd_acc) - CNT_W'(rsp_hs);
    pmem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_v[RD_LAT-1]),
        .pop   (rsp_hs),
        .din   (pipe[RD_LAT-1]),
        .dout  (head),
        .empty (rsp_empty)
    );
endmodule

// File: tb/tb_mem_pmem.sv
// tb_mem_pmem: two DUTs (RD_LAT 1 and 3) on shared stimulus, each checked every cycle against a queue-based model.
module tb_mem_pmem;
    logic clk = 0, rst = 0, enable = 0, rd_wr = 0, rd_ready = 1, perr_inj = 0;
    logic [2:0] addr = 0;
    logic [7:0] wr_data = 0;
    logic [1:0] ready, rd_valid, init_done;
    logic [7:0] rd_data [2];
`ifdef PMEM_PARITY_EN
    logic [1:0] rd_perr;
`endif
    int total = 0, bad = 0;
    always #5 clk = ~clk;

    mem_pmem #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1), .RSP_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data),
        .ready(ready[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_data(rd_data[0]),
`ifdef PMEM_PARITY_EN
        .perr_inj(perr_inj), .rd_perr(rd_perr[0]),
`endif
        .init_done(init_done[0]));
    mem_pmem #(.DATA_W(8), .ADDR_W(3), .RD_LAT(3), .RSP_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data),
        .ready(ready[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_data(rd_data[1]),
`ifdef PMEM_PARITY_EN
        .perr_inj(perr_inj), .rd_perr(rd_perr[1]),
`endif
        .init_done(init_done[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents plus a queue of (data, cycle it becomes visible).
    int lat [2] = '{1, 3};
    logic [7:0] mm [2][8];
    logic [7:0] qd [2][8];
    int qt [2][8];
`ifdef PMEM_PARITY_EN
    logic mp [2][8];
    logic qp [2][8];
`endif
    int qh [2] = '{0, 0}, qn [2] = '{0, 0}, ic [2] = '{0, 0};
    logic [1:0] run = 0, e_ready = 0, e_valid = 0;
    int now = 0;
    logic was_rst = 0;

    always @(posedge clk) begin : model
        int t;
        now++;
        was_rst = !rst;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                qn[k] = 0; qh[k] = 0; ic[k] = 0; run[k] = 0;
            end else if (!run[k]) begin
                mm[k][ic[k]] = 8'h00;
`ifdef PMEM_PARITY_EN
                mp[k][ic[k]] = 1'b0;
`endif
                ic[k]++;
                run[k] = (ic[k] == 8);
            end else begin
                if (e_valid[k] && rd_ready) begin
                    qh[k] = (qh[k] + 1) % 8;
                    qn[k]--;
                end
                if (enable && e_ready[k]) begin
                    if (rd_wr) begin
                        t = (qh[k] + qn[k]) % 8;
                        qd[k][t] = mm[k][addr];
                        qt[k][t] = now + lat[k];
`ifdef PMEM_PARITY_EN
                        qp[k][t] = mp[k][addr];
`endif
                        qn[k]++;
                    end else begin
                        mm[k][addr] = wr_data;
`ifdef PMEM_PARITY_EN
                        mp[k][addr] = perr_inj;
`endif
                    end
                end
            end
            e_ready[k] = run[k] && qn[k] < 4;
            e_valid[k] = qn[k] > 0 && qt[k][qh[k]] <= now;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ready%0d", k), ready[k], e_ready[k]);
            check($sformatf("rd_valid%0d", k), rd_valid[k], e_valid[k]);
            check($sformatf("init_done%0d", k), init_done[k], run[k]);
            if (was_rst) check($sformatf("rst_data%0d", k), rd_data[k], 8'h00);
            if (e_valid[k]) begin
                check($sformatf("rd_data%0d", k), rd_data[k], qd[k][qh[k]]);
`ifdef PMEM_PARITY_EN
                check($sformatf("rd_perr%0d", k), rd_perr[k], qp[k][qh[k]]);
`endif
            end
        end
    end

    // Issues one request once both DUTs are expected to be ready.
    task automatic req(input logic rw, input logic [2:0] a, input logic [7:0] d, input logic inj);
        int n = 0;
        while (e_ready != 2'b11 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", e_ready, 2'b11);
        enable = 1; rd_wr = rw; addr = a; wr_data = d; perr_inj = inj;
        @(negedge clk);
        enable = 0; perr_inj = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (12) @(negedge clk);
        for (int a = 0; a < 8; a++) req(1, 3'(a), 8'h00, 0);
        repeat (6) @(negedge clk);
        req(0, 3'd3, 8'hA5, 0);
        req(1, 3'd3, 8'h00, 0);
        repeat (6) @(negedge clk);
        for (int a = 0; a < 6; a++) req(0, 3'(a), 8'(8'h10 + a), 0);
        repeat (2) @(negedge clk);
        rd_ready = 0;
        for (int a = 0; a < 4; a++) req(1, 3'(a), 8'h00, 0);
        enable = 1; rd_wr = 1; addr = 3'd4;
        repeat (3) @(negedge clk);
        rd_ready = 1;
        @(negedge clk);
        enable = 0;
        req(1, 3'd4, 8'h00, 0);
        req(1, 3'd5, 8'h00, 0);
        repeat (10) @(negedge clk);
        req(0, 3'd6, 8'h77, 0);
        rd_ready = 0;
        for (int a = 0; a < 3; a++) req(1, 3'(a), 8'h00, 0);
        rst = 0;
        @(negedge clk);
        rst = 1;
        rd_ready = 1;
        repeat (10) @(negedge clk);
        req(1, 3'd6, 8'h00, 0);
        repeat (6) @(negedge clk);
`ifdef PMEM_PARITY_EN
        req(0, 3'd2, 8'h3C, 1);
        req(1, 3'd2, 8'h00, 0);
        repeat (6) @(negedge clk);
        req(0, 3'd2, 8'h3C, 0);
        req(1, 3'd2, 8'h00, 0);
        repeat (6) @(negedge clk);
`endif
        for (int i = 0; i < 400; i++) begin
            enable   = 1'($urandom_range(0, 1));
            rd_wr    = 1'($urandom_range(0, 1));
            addr     = 3'($urandom);
            wr_data  = 8'($urandom);
            rd_ready = $urandom_range(0, 9) < 7;
            perr_inj = $urandom_range(0, 9) == 0;
            rst      = (i != 200);
            @(negedge clk);
        end
        enable = 0; rst = 1; rd_ready = 1; perr_inj = 0;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
